// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix result writer and its index walker.
package matrix_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Index width for a dimension of n entries; a single entry still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_index_walker.sv
// Row/column walker over a ROWS x COLS matrix in row-major or column-major
// order. The walk order is captured on clear and held until the next clear.
// The counters never leave the ranges 0..ROWS-1 and 0..COLS-1.
module matrix_index_walker
  import matrix_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int RIDX_W = idx_w(ROWS),
  parameter int CIDX_W = idx_w(COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              col_major,
  input  logic              advance,
  output logic [RIDX_W-1:0] row,
  output logic [CIDX_W-1:0] col,
  output logic              is_last
);

  logic [RIDX_W-1:0] row_q, row_d;
  logic [CIDX_W-1:0] col_q, col_d;
  logic              mode_q, mode_d;
  logic              row_end;
  logic              col_end;

  assign row_end = (row_q == RIDX_W'(ROWS - 1));
  assign col_end = (col_q == CIDX_W'(COLS - 1));

  // Next index: clear restarts at (0,0); advance steps the inner dimension and
  // carries into the outer one when the inner dimension wraps.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    mode_d = mode_q;
    if (clear) begin
      row_d  = '0;
      col_d  = '0;
      mode_d = col_major;
    end else if (advance) begin
      if (!mode_q) begin
        col_d = col_end ? '0 : col_q + CIDX_W'(1);
        if (col_end) begin
          row_d = row_end ? '0 : row_q + RIDX_W'(1);
        end
      end else begin
        row_d = row_end ? '0 : row_q + RIDX_W'(1);
        if (row_end) begin
          col_d = col_end ? '0 : col_q + CIDX_W'(1);
        end
      end
    end
  end

  // Index and mode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      mode_q <= mode_d;
    end
  end

  assign row     = row_q;
  assign col     = col_q;
  assign is_last = row_end && col_end;

endmodule

// File: rtl/matrix_result_writer.sv
// Drains a ROWS x COLS result matrix from the result store onto a valid/ready
// stream, one element per request. Optional build macro:
//   MATRIX_WRITER_CHECKSUM_EN - adds a running XOR checksum of accepted data.
//
// state | meaning
// IDLE  | waiting for start; start latches the walk order and clears indices
// REQ   | rd_req high for one cycle with the current (rd_row, rd_col)
// WAIT  | waiting for rd_vld; captures rd_data and marks the final element
// OUT   | element held on the stream until out_ready
// DONE  | one-cycle done pulse, busy low, start ignored
module matrix_result_writer
  import matrix_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = DEFAULT_DATA_W,
  // Derived from ROWS/COLS; leave at default.
  parameter int RIDX_W = idx_w(ROWS),
  parameter int CIDX_W = idx_w(COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              col_major,
  output logic              rd_req,
  output logic [RIDX_W-1:0] rd_row,
  output logic [CIDX_W-1:0] rd_col,
  input  logic              rd_vld,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef MATRIX_WRITER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_e            state_q, state_d;
  logic              rd_req_q, rd_req_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              walk_clear;
  logic              walk_adv;
  logic              walk_last;

  matrix_index_walker #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .RIDX_W (RIDX_W),
    .CIDX_W (CIDX_W)
  ) u_walker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (walk_clear),
    .col_major (col_major),
    .advance   (walk_adv),
    .row       (rd_row),
    .col       (rd_col),
    .is_last   (walk_last)
  );

  // Next-state and registered-output logic. Outputs are computed one cycle
  // ahead so rd_req/out_valid/done line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    rd_req_d    = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    walk_clear  = 1'b0;
    walk_adv    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          walk_clear = 1'b1;
          busy_d     = 1'b1;
          rd_req_d   = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd_vld) begin
          out_data_d  = rd_data;
          out_valid_d = 1'b1;
          out_last_d  = walk_last;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            walk_adv = 1'b1;
            rd_req_d = 1'b1;
            state_d  = ST_REQ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any drain in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_req_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_req_q    <= rd_req_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_req    = rd_req_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef MATRIX_WRITER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Running XOR of accepted elements; restarts on an accepted start so the
  // value from the done cycle stays put until the next drain begins.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == ST_IDLE && start) begin
      checksum_d = '0;
    end else if (state_q == ST_OUT && out_ready) begin
      checksum_d = checksum_q ^ out_data_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_matrix_result_writer.sv
// Bench for matrix_result_writer: three instances (2x3, 4x4, 1x1) driven one
// at a time. The expected element order, data and checksum come from plain
// row/column arithmetic over a bench-side memory image.
module tb_matrix_result_writer;

  localparam int NI = 3;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_i     [NI];
  logic          cm_i        [NI];
  logic          rd_vld_i    [NI];
  logic          out_ready_i [NI];
  logic [DW-1:0] rd_data_i   [NI];
  logic          rd_req_o    [NI];
  logic          ov_o        [NI];
  logic          ol_o        [NI];
  logic          busy_o      [NI];
  logic          done_o      [NI];
  logic [3:0]    row_o       [NI];
  logic [3:0]    col_o       [NI];
  logic [DW-1:0] od_o        [NI];
`ifdef MATRIX_WRITER_CHECKSUM_EN
  logic [DW-1:0] cks_o       [NI];
`endif

  logic [0:0] a_row;
  logic [1:0] a_col;
  logic [1:0] b_row;
  logic [1:0] b_col;
  logic [0:0] c_row;
  logic [0:0] c_col;

  assign row_o[0] = {3'b000, a_row};
  assign col_o[0] = {2'b00, a_col};
  assign row_o[1] = {2'b00, b_row};
  assign col_o[1] = {2'b00, b_col};
  assign row_o[2] = {3'b000, c_row};
  assign col_o[2] = {3'b000, c_col};

  matrix_result_writer #(.ROWS(2), .COLS(3), .DATA_W(DW)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .col_major(cm_i[0]),
    .rd_req(rd_req_o[0]), .rd_row(a_row), .rd_col(a_col),
    .rd_vld(rd_vld_i[0]), .rd_data(rd_data_i[0]),
    .out_data(od_o[0]), .out_valid(ov_o[0]), .out_ready(out_ready_i[0]),
    .out_last(ol_o[0]), .busy(busy_o[0]), .done(done_o[0])
`ifdef MATRIX_WRITER_CHECKSUM_EN
    , .checksum(cks_o[0])
`endif
  );

  matrix_result_writer #(.ROWS(4), .COLS(4), .DATA_W(DW)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .col_major(cm_i[1]),
    .rd_req(rd_req_o[1]), .rd_row(b_row), .rd_col(b_col),
    .rd_vld(rd_vld_i[1]), .rd_data(rd_data_i[1]),
    .out_data(od_o[1]), .out_valid(ov_o[1]), .out_ready(out_ready_i[1]),
    .out_last(ol_o[1]), .busy(busy_o[1]), .done(done_o[1])
`ifdef MATRIX_WRITER_CHECKSUM_EN
    , .checksum(cks_o[1])
`endif
  );

  matrix_result_writer #(.ROWS(1), .COLS(1), .DATA_W(DW)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_i[2]), .col_major(cm_i[2]),
    .rd_req(rd_req_o[2]), .rd_row(c_row), .rd_col(c_col),
    .rd_vld(rd_vld_i[2]), .rd_data(rd_data_i[2]),
    .out_data(od_o[2]), .out_valid(ov_o[2]), .out_ready(out_ready_i[2]),
    .out_last(ol_o[2]), .busy(busy_o[2]), .done(done_o[2])
`ifdef MATRIX_WRITER_CHECKSUM_EN
    , .checksum(cks_o[2])
`endif
  );

  logic [DW-1:0] mem [NI][16];
  int tests = 0;
  int fails = 0;

  function automatic int nrows(input int k);
    return (k == 0) ? 2 : (k == 1) ? 4 : 1;
  endfunction

  function automatic int ncols(input int k);
    return (k == 0) ? 3 : (k == 1) ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int k);
    chk("z_rd_req", rd_req_o[k], 0);
    chk("z_out_valid", ov_o[k], 0);
    chk("z_out_last", ol_o[k], 0);
    chk("z_busy", busy_o[k], 0);
    chk("z_done", done_o[k], 0);
    chk("z_rd_row", row_o[k], 0);
    chk("z_rd_col", col_o[k], 0);
    chk("z_out_data", od_o[k], 0);
  endtask

  task automatic fill(input int k, input bit pattern);
    for (int r = 0; r < nrows(k); r++)
      for (int c = 0; c < ncols(k); c++)
        mem[k][r*ncols(k)+c] = pattern ? DW'(r*16 + c) : $urandom;
  endtask

  // One complete drain on instance k, checked cycle by cycle against the
  // order computed from the walk rule. abort_e >= 0 resets mid-WAIT of that
  // element; exp_done_t > 0 also checks the cycle of the done pulse.
  task automatic drain(input int k, input bit cm, input int lat_max, input bit rnd_ready,
                       input int stall_e, input int stall_n, input bit poke_start,
                       input int abort_e, input int exp_done_t);
    int R, C, N, t, e, held, vld_at, req_t;
    int er[16];
    int ec[16];
    bit outstanding, done_seen, rdy;
    logic [DW-1:0] x;
    R = nrows(k); C = ncols(k); N = R * C;
    x = '0;
    for (int i = 0; i < N; i++) begin
      if (cm) begin er[i] = i % R; ec[i] = i / R; end
      else begin er[i] = i / C; ec[i] = i % C; end
      x ^= mem[k][er[i]*C+ec[i]];
    end
    @(negedge clk);
    start_i[k] = 1'b1; cm_i[k] = cm; rd_vld_i[k] = 1'b0; out_ready_i[k] = 1'b0;
    t = 0; e = 0; held = 0; vld_at = -10; req_t = -10;
    outstanding = 0; done_seen = 0;
    while (!done_seen && t < 3000) begin
      @(negedge clk);
      t++;
      start_i[k] = 1'b0;
      if (poke_start && $urandom_range(0, 3) == 0) begin
        start_i[k] = 1'b1;
        cm_i[k] = 1'($urandom_range(0, 1));
      end
      if (t == vld_at + 1) chk("ov_after_vld", ov_o[k], 1);
      if (done_o[k]) begin
        done_seen = 1;
        chk("done_elems", e, N);
        chk("done_busy", busy_o[k], 0);
        if (exp_done_t > 0) chk("done_cycle", t, exp_done_t);
`ifdef MATRIX_WRITER_CHECKSUM_EN
        chk("checksum", cks_o[k], x);
`endif
        start_i[k] = poke_start;
        rd_vld_i[k] = 1'b0;
        out_ready_i[k] = 1'b0;
      end else begin
        chk("busy", busy_o[k], 1);
        if (rd_req_o[k]) begin
          chk("req_legal", outstanding, 0);
          chk("req_row", row_o[k], er[e]);
          chk("req_col", col_o[k], ec[e]);
          outstanding = 1;
          req_t = t;
          vld_at = t + ((e == abort_e) ? 3 : $urandom_range(lat_max, 1));
        end
        if (abort_e == e && outstanding && t == req_t + 1) begin
          rst_n = 1'b0;
          #1;
          chk_zero(k);
          start_i[k] = 1'b0; rd_vld_i[k] = 1'b0; out_ready_i[k] = 1'b0;
          @(negedge clk);
          chk_zero(k);
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (ov_o[k]) begin
          chk("out_data", od_o[k], mem[k][er[e]*C+ec[e]]);
          chk("out_last", ol_o[k], e == N - 1);
          held++;
          if (e == stall_e && held <= stall_n) rdy = 0;
          else if (rnd_ready) rdy = 1'($urandom_range(0, 1));
          else rdy = 1;
          out_ready_i[k] = rdy;
          rd_vld_i[k] = 1'($urandom_range(0, 1));
          rd_data_i[k] = $urandom;
          if (rdy) begin e++; outstanding = 0; held = 0; end
        end else begin
          out_ready_i[k] = 1'($urandom_range(0, 1));
          if (t == vld_at) begin
            rd_vld_i[k] = 1'b1;
            rd_data_i[k] = mem[k][er[e]*C+ec[e]];
          end else begin
            rd_vld_i[k] = 1'b0;
            rd_data_i[k] = $urandom;
          end
        end
      end
    end
    chk("done_seen", done_seen, 1);
    @(negedge clk);
    start_i[k] = 1'b0;
    chk("post_done", done_o[k], 0);
    chk("post_busy", busy_o[k], 0);
    chk("post_req", rd_req_o[k], 0);
    @(negedge clk);
    chk("idle_req", rd_req_o[k], 0);
    chk("idle_busy", busy_o[k], 0);
`ifdef MATRIX_WRITER_CHECKSUM_EN
    chk("checksum_hold", cks_o[k], x);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      start_i[k] = 1'b0; cm_i[k] = 1'b0; rd_vld_i[k] = 1'b0;
      out_ready_i[k] = 1'b0; rd_data_i[k] = '0;
    end
    fill(0, 1);
    fill(1, 0);
    mem[2][0] = 32'hDEADBEEF;
    #1;
    for (int k = 0; k < NI; k++) chk_zero(k);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    drain(0, 0, 1, 0, -1, 0, 0, -1, 19);
    drain(0, 1, 1, 0, -1, 0, 0, -1, 19);
    drain(1, 0, 1, 0, 1, 5, 0, -1, 54);
    drain(1, 1, 4, 1, -1, 0, 1, -1, 0);
    drain(0, 0, 3, 1, -1, 0, 1, -1, 0);
    drain(1, 0, 3, 1, -1, 0, 0, 4, 0);
    fill(1, 0);
    drain(1, 0, 2, 1, -1, 0, 0, -1, 0);
    drain(2, 0, 1, 0, -1, 0, 0, -1, 4);
    drain(2, 1, 3, 1, -1, 0, 1, -1, 0);
    for (int n = 0; n < 6; n++) begin
      int k;
      k = $urandom_range(0, 2);
      if (k != 2) fill(k, 0);
      drain(k, 1'($urandom_range(0, 1)), $urandom_range(4, 1), 1, -1, 0, 1, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
